count_monitor: RTL and testbench
================================

COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2: consecutive equal synchronized samples needed to accept a count value (legal range 1..8).
REQ-002 SHALL have parameter WRAP_W, default 8: width of the wrap counter.
REQ-003 SHALL have port clk, input, 1: sampling clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port qa/qb/qc, input, 1 each: ripple-counter bits, asynchronous to clk; count = {qc,qb,qa}.
REQ-006 SHALL have port m, input, 1: counter mode, asynchronous to clk; 0 = up, 1 = down.
REQ-007 SHALL have port clr, input, 1: synchronous one-cycle clear of the error and wrap state.
REQ-008 SHALL have port count_q, output, 3: last accepted count.
REQ-009 SHALL have port count_vld, output, 1: high once any value has been accepted since reset.
REQ-010 SHALL have port step_pulse, output, 1: one-cycle pulse on each accepted change.
REQ-011 SHALL have port wrap_pulse, output, 1: one-cycle pulse on an accepted 7->0 (up) or 0->7 (down) step.
REQ-012 SHALL have port wrap_cnt, output, WRAP_W: number of wraps, modulo 2^WRAP_W.
REQ-013 SHALL have port dir_q, output, 1: synchronized mode.
REQ-014 SHALL have port step_err, output, 1: sticky illegal-step flag.

Function
REQ-015 SHALL pass qa, qb, qc and m each through a 2-flop synchronizer; dir_q is the m synchronizer output.
REQ-016 SHALL run a stability counter that resets to 0 whenever the synchronized 3-bit vector differs from its previous-cycle value and otherwise increments, saturating at STABLE_CYCLES-1.
REQ-017 SHALL deem a sample stable when the stability counter equals STABLE_CYCLES-1.
REQ-018 SHALL run an FSM with the states INIT, TRACK and ERR.
REQ-019 In INIT, the first stable sample SHALL be loaded into count_q, set count_vld, move the FSM to TRACK, and produce no step_pulse and no error check.
REQ-020 In TRACK or ERR, a stable sample that differs from count_q SHALL be accepted.
REQ-021 On acceptance, count_q SHALL load the new value and step_pulse SHALL be high the following cycle (one-cycle pulse).
REQ-022 The expected value SHALL be count_q+1 mod 8 when dir_q=0 and count_q-1 mod 8 when dir_q=1.
REQ-023 For the first acceptance after any dir_q change, both +1 and -1 SHALL be legal.
REQ-024 An accepted value that is not legal SHALL set step_err, move TRACK to ERR, and still update count_q; it SHALL assert no wrap_pulse.
REQ-025 A legal step 7->0 with dir_q=0, or 0->7 with dir_q=1, SHALL pulse wrap_pulse in the same cycle as step_pulse and increment wrap_cnt, wrapping modulo 2^WRAP_W.
REQ-026 ERR SHALL keep tracking and wrap counting exactly as TRACK does.
REQ-027 clr SHALL, on the next edge, zero step_err and wrap_cnt and return ERR to TRACK; it SHALL not affect count_q or count_vld.
REQ-028 When clr coincides with an acceptance, clr SHALL win for step_err and wrap_cnt, while step_pulse and wrap_pulse still fire.
REQ-029 A stable sample equal to count_q SHALL cause no action.
REQ-030 Latency from a settled input change to step_pulse SHALL be 2 (synchronizer) + STABLE_CYCLES + 1 clk cycles (5 at default).

Reset
REQ-031 While rst_n=0, all synchronizer flops SHALL be 0 and the stability counter 0.
REQ-032 While rst_n=0, the FSM SHALL be in INIT, count_q=3'b111, and count_vld, step_pulse, wrap_pulse, wrap_cnt, step_err and dir_q SHALL all be 0.
REQ-033 Deassertion of rst_n SHALL be synchronized internally (2-flop release) so the first active edge is glitch-free.
REQ-034 A reset asserted mid-operation SHALL return the block to INIT with no residual pulse.

Verification
REQ-035 Reset, hold inputs at 111 with m=0 -> count_vld=1 and count_q=111 after 4 cycles; no step_pulse, step_err=0.
REQ-036 Up sequence 111,000,001 ... 111 with m=0, each value held 10 cycles -> 8 step_pulse, 1 wrap_pulse (7->0), wrap_cnt=1, step_err=0, each step_pulse 5 cycles after the input change.
REQ-037 Inject a 1-cycle ripple glitch 011->001->100 -> 001 is never accepted; a single step 011->100, no error.
REQ-038 With m=1, count 010 then jump to 101 -> step_err=1 and state ERR; then pulse clr -> step_err=0, wrap_cnt=0, count_q=101.
REQ-039 Toggle m from 0 to 1 at count 011, then input 010 -> legal, step_err=0; a subsequent 000 -> step_err=1.
REQ-040 Assert rst_n=0 mid-sequence at count 101 -> count_q=111 and count_vld=0 immediately; after release it re-enters INIT and accepts 101 with no step_pulse.

Source files
------------

// File: rtl/count_monitor.sv
// count_monitor: samples an asynchronous 3-bit ripple counter and accepts settled values.
// Tracks steps, wraps and illegal steps, and reports them on pulse, counter and flag outputs.
//   clk, rst_n  : sampling clock, async active-low reset (release synchronized)
//   qa, qb, qc  : ripple counter bits, count = {qc,qb,qa}, asynchronous
//   m           : counter mode, 0 = up, 1 = down, asynchronous
//   clr         : one-cycle clear of step_err / wrap_cnt
//   count_q     : last accepted count
//   count_vld   : a value has been accepted since reset
//   step_pulse  : one-cycle pulse per accepted change
//   wrap_pulse  : one-cycle pulse per legal 7->0 (up) / 0->7 (down)
//   wrap_cnt    : wrap count modulo 2^WRAP_W
//   dir_q       : synchronized mode
//   step_err    : sticky illegal-step flag
module count_monitor #(
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              qa,
    input  logic              qb,
    input  logic              qc,
    input  logic              m,
    input  logic              clr,
    output logic [2:0]        count_q,
    output logic              count_vld,
    output logic              step_pulse,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              dir_q,
    output logic              step_err
);

    typedef enum logic [1:0] {INIT, TRACK, ERR} state_t;

    localparam logic [2:0] SMAX = 3'(STABLE_CYCLES - 1);

    state_t     state;
    logic [1:0] rs;
    logic       run;
    logic [3:0] s1, s2;
    logic [2:0] vec, vec_d;
    logic [2:0] cnt;
    logic       stable;
    logic       dir_last, dir_free;
    logic [2:0] up1, dn1, fwd, rev;
    logic       free, legal, wrap, accept;

    // Reset asserts immediately, releases two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rs <= 2'b00;
        else        rs <= {rs[0], 1'b1};
    end

    assign run = rs[1];

    // Synchronizers run during the release window so they hold real
    // data by the time the rest of the block starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 4'd0;
            s2 <= 4'd0;
        end else begin
            s1 <= {m, qc, qb, qa};
            s2 <= s1;
        end
    end

    assign vec   = s2[2:0];
    assign dir_q = s2[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_d <= 3'd0;
            cnt   <= 3'd0;
        end else if (!run) begin
            vec_d <= 3'd0;
            cnt   <= 3'd0;
        end else begin
            vec_d <= vec;
            if (vec != vec_d)  cnt <= 3'd0;
            else if (cnt != SMAX) cnt <= cnt + 3'd1;
        end
    end

    // The registered counter lags by one cycle, so also require the
    // current sample to match the previous one.
    assign stable = (cnt == SMAX) && (vec == vec_d);

    assign up1    = count_q + 3'd1;
    assign dn1    = count_q - 3'd1;
    assign fwd    = dir_q ? dn1 : up1;
    assign rev    = dir_q ? up1 : dn1;
    assign free   = dir_free | (dir_q != dir_last);
    assign legal  = (vec == fwd) || (free && (vec == rev));
    assign wrap   = legal && (dir_q ? (count_q == 3'd0 && vec == 3'd7)
                                    : (count_q == 3'd7 && vec == 3'd0));
    assign accept = stable && (vec != count_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            count_q    <= 3'b111;
            count_vld  <= 1'b0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            dir_last   <= 1'b0;
            dir_free   <= 1'b0;
        end else if (!run) begin
            state      <= INIT;
            count_q    <= 3'b111;
            count_vld  <= 1'b0;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            dir_last   <= 1'b0;
            dir_free   <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
            dir_last   <= dir_q;
            dir_free   <= free;
            unique case (state)
                INIT: begin
                    if (stable) begin
                        count_q   <= vec;
                        count_vld <= 1'b1;
                        state     <= TRACK;
                    end
                end
                TRACK, ERR: begin
                    if (accept) begin
                        count_q    <= vec;
                        step_pulse <= 1'b1;
                        dir_free   <= 1'b0;
                        if (!legal) begin
                            step_err <= 1'b1;
                            state    <= ERR;
                        end else if (wrap) begin
                            wrap_pulse <= 1'b1;
                            wrap_cnt   <= wrap_cnt + WRAP_W'(1);
                        end
                    end
                end
                default: state <= INIT;
            endcase
            // clr overrides any same-cycle error or wrap update.
            if (clr) begin
                step_err <= 1'b0;
                wrap_cnt <= '0;
                if (state != INIT) state <= TRACK;
            end
        end
    end

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: scenario tasks for count_monitor with a step scoreboard.
// Expected steps are queued when driven and matched against observed step_pulse events.
module tb_count_monitor;

    typedef struct packed {
        logic [2:0] cnt;
        logic       wrap;
        logic [7:0] lat;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       qa = 1'b1, qb = 1'b1, qc = 1'b1;
    logic       m = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] count_q;
    logic       count_vld;
    logic       step_pulse;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;
    logic       dir_q;
    logic       step_err;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  nwrap = 0;
    ev_t exp_q[$];
    ev_t obs_q[$];

    count_monitor #(.STABLE_CYCLES(2), .WRAP_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .qa(qa), .qb(qb), .qc(qc), .m(m), .clr(clr),
        .count_q(count_q), .count_vld(count_vld),
        .step_pulse(step_pulse), .wrap_pulse(wrap_pulse),
        .wrap_cnt(wrap_cnt), .dir_q(dir_q), .step_err(step_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic hold(input logic [2:0] v, input int n);
        int t0;
        ev_t o;
        @(negedge clk);
        {qc, qb, qa} = v;
        t0 = cyc;
        repeat (n) begin
            @(negedge clk);
            if (step_pulse === 1'b1) begin
                o.cnt  = count_q;
                o.wrap = wrap_pulse;
                o.lat  = 8'(cyc - t0);
                obs_q.push_back(o);
            end
            if (wrap_pulse === 1'b1) nwrap++;
        end
    endtask

    task automatic set_m(input logic b);
        @(negedge clk);
        m = b;
        repeat (6) @(negedge clk);
    endtask

    task automatic push(input logic [2:0] v, input logic w);
        ev_t e;
        e.cnt  = v;
        e.wrap = w;
        e.lat  = 8'd5;
        exp_q.push_back(e);
    endtask

    task automatic pulse_clr;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset;
        {qc, qb, qa} = 3'b111;
        m = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({count_q, count_vld, step_pulse, wrap_pulse, wrap_cnt, step_err, dir_q} !== {3'b111, 13'd0}) begin
            n_bad++;
            $display("FAIL rst_state: got q=%b vld=%b sp=%b wp=%b wc=%0d err=%b dir=%b, want q=111 rest 0",
                     count_q, count_vld, step_pulse, wrap_pulse, wrap_cnt, step_err, dir_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hold(3'b111, 10);
        n_cmp++;
        if (count_vld !== 1'b1 || count_q !== 3'b111) begin
            n_bad++;
            $display("FAIL init_load: got vld=%b q=%b, want vld=1 q=111", count_vld, count_q);
        end
        n_cmp++;
        if (obs_q.size() != 0 || step_err !== 1'b0) begin
            n_bad++;
            $display("FAIL init_nostep: got steps=%0d err=%b, want steps=0 err=0", obs_q.size(), step_err);
        end
        obs_q.delete();
    endtask

    task automatic test_up;
        ev_t e, o;
        logic [2:0] v;
        nwrap = 0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            push(v, v == 3'd0);
            hold(v, 10);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL up_step: got no pulse, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL up_step: got cnt=%0d wrap=%b lat=%0d, want cnt=%0d wrap=%b lat=%0d",
                             o.cnt, o.wrap, o.lat, e.cnt, e.wrap, e.lat);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL up_extra: got %0d extra pulses, want 0", obs_q.size());
        end
        obs_q.delete();
        n_cmp++;
        if (nwrap != 1 || wrap_cnt !== 8'd1 || step_err !== 1'b0) begin
            n_bad++;
            $display("FAIL up_wrap: got wraps=%0d wc=%0d err=%b, want 1 1 0", nwrap, wrap_cnt, step_err);
        end
    endtask

    task automatic test_glitch;
        ev_t e, o;
        push(3'd0, 1'b1); hold(3'd0, 10);
        push(3'd1, 1'b0); hold(3'd1, 10);
        push(3'd2, 1'b0); hold(3'd2, 10);
        push(3'd3, 1'b0); hold(3'd3, 10);
        hold(3'b001, 1);
        push(3'd4, 1'b0); hold(3'b100, 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL glitch_step: got no pulse, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL glitch_step: got cnt=%0d wrap=%b lat=%0d, want cnt=%0d wrap=%b lat=%0d",
                             o.cnt, o.wrap, o.lat, e.cnt, e.wrap, e.lat);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL glitch_extra: got %0d extra pulses, want 0", obs_q.size());
        end
        obs_q.delete();
        n_cmp++;
        if (step_err !== 1'b0 || wrap_cnt !== 8'd2) begin
            n_bad++;
            $display("FAIL glitch_flags: got err=%b wc=%0d, want 0 2", step_err, wrap_cnt);
        end
    endtask

    task automatic test_err_clr;
        ev_t e, o;
        set_m(1'b1);
        push(3'd3, 1'b0); hold(3'b011, 10);
        push(3'd2, 1'b0); hold(3'b010, 10);
        push(3'd5, 1'b0); hold(3'b101, 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL err_step: got no pulse, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL err_step: got cnt=%0d wrap=%b lat=%0d, want cnt=%0d wrap=%b lat=%0d",
                             o.cnt, o.wrap, o.lat, e.cnt, e.wrap, e.lat);
                end
            end
        end
        obs_q.delete();
        n_cmp++;
        if (step_err !== 1'b1 || wrap_cnt !== 8'd2 || dir_q !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got err=%b wc=%0d dir=%b, want 1 2 1", step_err, wrap_cnt, dir_q);
        end
        pulse_clr;
        n_cmp++;
        if (step_err !== 1'b0 || wrap_cnt !== 8'd0 || count_q !== 3'b101 || count_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL err_clr: got err=%b wc=%0d q=%b vld=%b, want 0 0 101 1",
                     step_err, wrap_cnt, count_q, count_vld);
        end
    endtask

    task automatic test_dir_change;
        ev_t e, o;
        push(3'd4, 1'b0); hold(3'b100, 10);
        push(3'd3, 1'b0); hold(3'b011, 10);
        set_m(1'b0);
        set_m(1'b1);
        push(3'd2, 1'b0); hold(3'b010, 10);
        n_cmp++;
        if (step_err !== 1'b0) begin
            n_bad++;
            $display("FAIL dir_legal: got err=%b, want 0", step_err);
        end
        push(3'd0, 1'b0); hold(3'b000, 10);
        n_cmp++;
        if (step_err !== 1'b1) begin
            n_bad++;
            $display("FAIL dir_illegal: got err=%b, want 1", step_err);
        end
        pulse_clr;
        set_m(1'b0);
        push(3'd7, 1'b0); hold(3'b111, 10);
        n_cmp++;
        if (step_err !== 1'b0 || wrap_cnt !== 8'd0) begin
            n_bad++;
            $display("FAIL dir_rev: got err=%b wc=%0d, want 0 0", step_err, wrap_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL dir_step: got no pulse, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL dir_step: got cnt=%0d wrap=%b lat=%0d, want cnt=%0d wrap=%b lat=%0d",
                             o.cnt, o.wrap, o.lat, e.cnt, e.wrap, e.lat);
                end
            end
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        ev_t e, o;
        set_m(1'b1);
        push(3'd6, 1'b0); hold(3'b110, 10);
        push(3'd5, 1'b0); hold(3'b101, 10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++;
                $display("FAIL mid_step: got no pulse, want cnt=%0d", e.cnt);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL mid_step: got cnt=%0d wrap=%b lat=%0d, want cnt=%0d wrap=%b lat=%0d",
                             o.cnt, o.wrap, o.lat, e.cnt, e.wrap, e.lat);
                end
            end
        end
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (count_q !== 3'b111 || count_vld !== 1'b0 || step_pulse !== 1'b0 || dir_q !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst: got q=%b vld=%b sp=%b dir=%b, want 111 0 0 0",
                     count_q, count_vld, step_pulse, dir_q);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(3'b101, 12);
        n_cmp++;
        if (count_vld !== 1'b1 || count_q !== 3'b101 || obs_q.size() != 0 || step_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reinit: got vld=%b q=%b steps=%0d err=%b, want 1 101 0 0",
                     count_vld, count_q, obs_q.size(), step_err);
        end
        obs_q.delete();
    endtask

    initial begin
        test_reset;
        test_up;
        test_glitch;
        test_err_clr;
        test_dir_change;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
